// File: rtl/game_ctrl.sv
// game_ctrl: flappy-bird game sequencer. Runs the game FSM, drives the bird
// motion enable, schedules fall/lift ticks from one shared divider scaled by
// difficulty level, and tracks score/level from pipe-pass events.
// Optional feature macro: GAME_PAUSE_EN (adds a PAUSE state entered/left by
// a start-button press while playing).
//
// state    | meaning
// ---------|----------------------------------------------------------
// S_IDLE   | waiting for start; score, level and divider held cleared
// S_READY  | countdown before play; collisions and passes ignored
// S_PLAY   | bird active; ticks issued, score/level updated
// S_OVER   | game ended; score and level held for display
// S_PAUSE  | (GAME_PAUSE_EN only) play frozen, divider value kept

module game_ctrl #(
    parameter int unsigned FALL_DIV     = 700000,
    parameter int unsigned LIFT_DIV     = 900000,
    parameter int unsigned CNTDN_CYCLES = 50000000,
    parameter int unsigned LEVEL_STEP   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key1,
    input  logic       bird_over,
    input  logic       hit,
    input  logic       pass_pulse,
    output logic       is_start,
    output logic       fall_tick,
    output logic       lift_tick,
    output logic [6:0] score,
    output logic [1:0] level,
    output logic [1:0] state,
    output logic       game_over
);

    localparam int unsigned MAX_DIV = (FALL_DIV > LIFT_DIV) ? FALL_DIV : LIFT_DIV;
    localparam int unsigned MAX_AUX = (CNTDN_CYCLES > LEVEL_STEP) ? CNTDN_CYCLES : LEVEL_STEP;
    localparam int unsigned MAX_ALL = (MAX_DIV > MAX_AUX) ? MAX_DIV : MAX_AUX;
    localparam int          CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] CNTDN_LOAD = CW'(CNTDN_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST  = CW'(LEVEL_STEP - 1);
    localparam logic [6:0]    SCORE_MAX  = 7'd99;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_OVER  = 3'd3
`ifdef GAME_PAUSE_EN
        ,S_PAUSE = 3'd4
`endif
    } state_t;

    state_t        state_q, state_nxt;
    logic          key_q, key1_q;
    logic          start_rise;
    logic [CW-1:0] cntdn_q, cntdn_nxt;
    logic [CW-1:0] div_q, div_nxt;
    logic [CW-1:0] step_q, step_nxt;
    logic [6:0]    score_nxt;
    logic [1:0]    level_nxt;
    logic          fall_nxt, lift_nxt;
    logic [1:0]    state_enc_nxt;
    logic [31:0]   div_base, div_shift;
    logic [CW-1:0] limit_m1;

    // key_q resets high so a button held through reset is not a start
    assign start_rise = key_start & ~key_q;

    // Divider terminal value for the current direction and level, never below 1
    always_comb begin
        div_base  = key1 ? LIFT_DIV : FALL_DIV;
        div_shift = div_base >> level;
        if (div_shift <= 32'd1) begin
            limit_m1 = '0;
        end else begin
            limit_m1 = CW'(div_shift - 32'd1);
        end
    end

    // Next-state, counters, scoring and tick generation
    always_comb begin
        state_nxt = state_q;
        cntdn_nxt = cntdn_q;
        div_nxt   = div_q;
        step_nxt  = step_q;
        score_nxt = score;
        level_nxt = level;
        fall_nxt  = 1'b0;
        lift_nxt  = 1'b0;

        case (state_q)
            S_IDLE: begin
                score_nxt = '0;
                level_nxt = '0;
                step_nxt  = '0;
                div_nxt   = '0;
                if (start_rise) begin
                    state_nxt = S_READY;
                    cntdn_nxt = CNTDN_LOAD;
                end
            end
            S_READY: begin
                div_nxt = '0;
                if (cntdn_q == '0) begin
                    state_nxt = S_PLAY;
                end else begin
                    cntdn_nxt = cntdn_q - CW'(1);
                end
            end
            S_PLAY: begin
                if (hit | bird_over) begin
                    state_nxt = S_OVER;
`ifdef GAME_PAUSE_EN
                end else if (start_rise) begin
                    state_nxt = S_PAUSE;
`endif
                end else begin
                    // a direction change restarts the interval without a tick
                    if (key1 != key1_q) begin
                        div_nxt = '0;
                    end else if (div_q >= limit_m1) begin
                        // >= also covers a level-up that shrank the limit below div_q
                        div_nxt  = '0;
                        lift_nxt = key1;
                        fall_nxt = ~key1;
                    end else begin
                        div_nxt = div_q + CW'(1);
                    end
                    if (pass_pulse && (score != SCORE_MAX)) begin
                        score_nxt = score + 7'd1;
                        if (step_q == STEP_LAST) begin
                            step_nxt = '0;
                            if (level != 2'd3) begin
                                level_nxt = level + 2'd1;
                            end
                        end else begin
                            step_nxt = step_q + CW'(1);
                        end
                    end
                end
            end
            S_OVER: begin
                if (start_rise) begin
                    state_nxt = S_READY;
                    cntdn_nxt = CNTDN_LOAD;
                    score_nxt = '0;
                    level_nxt = '0;
                    step_nxt  = '0;
                    div_nxt   = '0;
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (start_rise) begin
                    state_nxt = S_PLAY;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        case (state_nxt)
            S_IDLE:  state_enc_nxt = 2'd0;
            S_READY: state_enc_nxt = 2'd1;
            S_PLAY:  state_enc_nxt = 2'd2;
            default: state_enc_nxt = 2'd3;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Counters, input history and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q     <= 1'b1;
            key1_q    <= 1'b0;
            cntdn_q   <= '0;
            div_q     <= '0;
            step_q    <= '0;
            score     <= '0;
            level     <= '0;
            fall_tick <= 1'b0;
            lift_tick <= 1'b0;
            is_start  <= 1'b0;
            game_over <= 1'b0;
            state     <= 2'd0;
        end else begin
            key_q     <= key_start;
            key1_q    <= key1;
            cntdn_q   <= cntdn_nxt;
            div_q     <= div_nxt;
            step_q    <= step_nxt;
            score     <= score_nxt;
            level     <= level_nxt;
            fall_tick <= fall_nxt;
            lift_tick <= lift_nxt;
            is_start  <= (state_nxt == S_PLAY);
            game_over <= (state_nxt == S_OVER);
            state     <= state_enc_nxt;
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: self-checking bench for game_ctrl with small divider values.
// Table-driven vectors, hand-written multi-cycle sequences, then randomized
// stimulus against a behavioural reference model.

module tb_game_ctrl;

    localparam int FALL  = 8;
    localparam int LIFT  = 12;
    localparam int CNTDN = 4;
    localparam int STEP  = 2;

    logic       clk = 1'b0;
    logic       rst, key_start, key1, bird_over, hit, pass_pulse;
    logic       is_start, fall_tick, lift_tick, game_over;
    logic [6:0] score;
    logic [1:0] level, state;

    int n_tests = 0;
    int n_fail  = 0;

    game_ctrl #(
        .FALL_DIV(FALL), .LIFT_DIV(LIFT), .CNTDN_CYCLES(CNTDN), .LEVEL_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .key_start(key_start), .key1(key1),
        .bird_over(bird_over), .hit(hit), .pass_pulse(pass_pulse),
        .is_start(is_start), .fall_tick(fall_tick), .lift_tick(lift_tick),
        .score(score), .level(level), .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit rst, ks, k1, h, bo, ps;
        int st, is, sc, lv, go, ft, lt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit ks, bit k1, bit h, bit bo, bit ps,
                                int st, int is, int sc, int lv, int go, int ft, int lt);
        vec_t v;
        v.rst = r; v.ks = ks; v.k1 = k1; v.h = h; v.bo = bo; v.ps = ps;
        v.st = st; v.is = is; v.sc = sc; v.lv = lv; v.go = go; v.ft = ft; v.lt = lt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string pfx, input int st, input int is, input int sc,
                           input int lv, input int go, input int ft, input int lt);
        chk({pfx, "_state"}, 32'(state), st);
        chk({pfx, "_is_start"}, 32'(is_start), is);
        chk({pfx, "_score"}, 32'(score), sc);
        chk({pfx, "_level"}, 32'(level), lv);
        chk({pfx, "_game_over"}, 32'(game_over), go);
        chk({pfx, "_fall_tick"}, 32'(fall_tick), ft);
        chk({pfx, "_lift_tick"}, 32'(lift_tick), lt);
    endtask

    // Advance until a tick of the wanted kind; n = cycles waited, other = wrong-kind ticks
    task automatic wait_tick(input string name, input bit lift, output int n, output int other);
        n = 0;
        other = 0;
        do begin
            cyc();
            n++;
            if (lift ? fall_tick : lift_tick) other++;
        end while (!(lift ? lift_tick : fall_tick) && n < 200);
        chk({name, "_seen"}, 32'(n < 200), 1);
    endtask

    task automatic start_game(input string name);
        rst = 1; key_start = 0; key1 = 0; hit = 0; bird_over = 0; pass_pulse = 0;
        cyc();
        rst = 0;
        cyc();
        key_start = 1;
        cyc();
        chk({name, "_ready"}, 32'(state), 1);
        key_start = 0;
        repeat (CNTDN) cyc();
        chk({name, "_play"}, 32'(state), 2);
    endtask

    // Behavioural reference: 0 idle, 1 ready, 2 play, 3 over, 4 pause
    int m_st, m_cd, m_div, m_score, m_keyq, m_k1q, m_ft, m_lt;

    task automatic model_reset();
        m_st = 0; m_cd = 0; m_div = 0; m_score = 0;
        m_keyq = 1; m_k1q = 0; m_ft = 0; m_lt = 0;
    endtask

    task automatic model_step(input bit ks, input bit k1, input bit h, input bit bo, input bit ps);
        bit rise;
        int lim, lvl;
        rise = ks && (m_keyq == 0);
        m_ft = 0;
        m_lt = 0;
        lvl = (m_score / STEP > 3) ? 3 : m_score / STEP;
        case (m_st)
            0: begin
                m_score = 0; m_div = 0;
                if (rise) begin m_st = 1; m_cd = CNTDN; end
            end
            1: begin
                m_div = 0;
                m_cd--;
                if (m_cd == 0) m_st = 2;
            end
            2: begin
                if (h || bo) m_st = 3;
`ifdef GAME_PAUSE_EN
                else if (rise) m_st = 4;
`endif
                else begin
                    lim = (k1 ? LIFT : FALL) >> lvl;
                    if (lim < 1) lim = 1;
                    if (int'(k1) != m_k1q) m_div = 0;
                    else begin
                        m_div++;
                        if (m_div >= lim) begin
                            m_div = 0;
                            if (k1) m_lt = 1; else m_ft = 1;
                        end
                    end
                    if (ps && m_score < 99) m_score++;
                end
            end
            3: if (rise) begin m_st = 1; m_cd = CNTDN; m_score = 0; m_div = 0; end
            4: if (rise) m_st = 2;
            default: ;
        endcase
        m_keyq = ks;
        m_k1q = k1;
    endtask

    initial begin
        int n, other, ticks, e_lv;
        rst = 1; key_start = 0; key1 = 0; hit = 0; bird_over = 0; pass_pulse = 0;

        // ---------------- table-driven vectors ----------------
        //          rst ks k1 h bo ps   st is sc lv go ft lt
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,  2, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,  2, 1, 2, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1,  3, 0, 2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  3, 0, 2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; key_start = tbl[i].ks; key1 = tbl[i].k1;
            hit = tbl[i].h; bird_over = tbl[i].bo; pass_pulse = tbl[i].ps;
            cyc();
            chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].is, tbl[i].sc,
                    tbl[i].lv, tbl[i].go, tbl[i].ft, tbl[i].lt);
        end

        // ---------------- tick spacing, lift, levels, saturation ----------------
        start_game("seq1");
        wait_tick("fall_first", 0, n, other);
        chk("fall_first_gap", 32'(n), FALL);
        wait_tick("fall_second", 0, n, other);
        chk("fall_gap", 32'(n), FALL);
        chk("fall_no_lift", 32'(other), 0);

        key1 = 1;
        cyc();
        wait_tick("lift_first", 1, n, other);
        chk("lift_first_gap", 32'(n), LIFT);
        chk("lift_first_no_fall", 32'(other), 0);
        wait_tick("lift_second", 1, n, other);
        chk("lift_gap", 32'(n), LIFT);
        chk("lift_no_fall", 32'(other), 0);

        key1 = 0;
        cyc();
        pass_pulse = 1;
        repeat (2) cyc();
        pass_pulse = 0;
        chk("lvl1_score", 32'(score), 2);
        chk("lvl1_level", 32'(level), 1);
        wait_tick("lvl1_sync", 0, n, other);
        wait_tick("lvl1_gap", 0, n, other);
        chk("lvl1_fall_gap", 32'(n), FALL >> 1);

        pass_pulse = 1;
        repeat (8) cyc();
        pass_pulse = 0;
        chk("lvl3_score", 32'(score), 10);
        chk("lvl3_level", 32'(level), 3);
        wait_tick("lvl3_sync", 0, n, other);
        wait_tick("lvl3_gap", 0, n, other);
        chk("lvl3_fall_gap", 32'(n), 1);

        pass_pulse = 1;
        repeat (95) cyc();
        chk("score_sat", 32'(score), 99);
        cyc();
        pass_pulse = 0;
        chk("score_sat_hold", 32'(score), 99);
        chk("level_sat", 32'(level), 3);

        // ---------------- collision beats simultaneous pass ----------------
        start_game("seq2");
        pass_pulse = 1;
        repeat (3) cyc();
        pass_pulse = 0;
        chk("pre_hit_score", 32'(score), 3);
        hit = 1; pass_pulse = 1;
        cyc();
        hit = 0; pass_pulse = 0;
        chk_all("hit_pass", 3, 0, 3, 1, 1, 0, 0);
        ticks = 0;
        repeat (12) begin
            cyc();
            ticks += int'(fall_tick) + int'(lift_tick);
        end
        chk("over_no_ticks", 32'(ticks), 0);
        chk("over_hold_score", 32'(score), 3);
        key_start = 1;
        cyc();
        key_start = 0;
        chk_all("restart", 1, 0, 0, 0, 0, 0, 0);

        // ---------------- reset mid-PLAY ----------------
        start_game("seq3");
        pass_pulse = 1;
        repeat (4) cyc();
        pass_pulse = 0;
        chk("mid_score", 32'(score), 4);
        chk("mid_level", 32'(level), 2);
        repeat (3) cyc();
        rst = 1;
        cyc();
        rst = 0;
        chk_all("rst_mid_play", 0, 0, 0, 0, 0, 0, 0);

        // ---------------- start press while playing ----------------
        start_game("seq4");
`ifdef GAME_PAUSE_EN
        wait_tick("pause_sync", 0, n, other);
        repeat (5) cyc();
        key_start = 1;
        cyc();
        chk("pause_state", 32'(state), 3);
        chk("pause_game_over", 32'(game_over), 0);
        chk("pause_is_start", 32'(is_start), 0);
        ticks = 0;
        repeat (20) begin
            hit = 1; pass_pulse = 1;
            cyc();
            ticks += int'(fall_tick) + int'(lift_tick);
        end
        hit = 0; pass_pulse = 0;
        chk("pause_no_ticks", 32'(ticks), 0);
        chk("pause_state_held", 32'(state), 3);
        chk("pause_score_held", 32'(score), 0);
        key_start = 0;
        cyc();
        key_start = 1;
        cyc();
        key_start = 0;
        chk("resume_state", 32'(state), 2);
        wait_tick("resume", 0, n, other);
        chk("resume_gap", 32'(n), 3);
`else
        key_start = 1;
        cyc();
        key_start = 0;
        chk("start_in_play_state", 32'(state), 2);
        chk("start_in_play_is_start", 32'(is_start), 1);
        wait_tick("start_in_play", 0, n, other);
        chk("start_in_play_gap", 32'(n), FALL - 1);
`endif

        // ---------------- randomized vs reference model ----------------
        rst = 1; key_start = 0; key1 = 0; hit = 0; bird_over = 0; pass_pulse = 0;
        cyc();
        model_reset();
        rst = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) key_start = ~key_start;
            if ($urandom_range(29) == 0) key1 = ~key1;
            hit        = ($urandom_range(299) == 0);
            bird_over  = ($urandom_range(299) == 0);
            pass_pulse = ($urandom_range(7) == 0);
            rst        = ($urandom_range(1499) == 0);
            cyc();
            if (rst) model_reset();
            else model_step(key_start, key1, hit, bird_over, pass_pulse);
            e_lv = (m_score / STEP > 3) ? 3 : m_score / STEP;
            chk_all($sformatf("rnd%0d", i), (m_st == 4) ? 3 : m_st, int'(m_st == 2),
                    m_score, e_lv, int'(m_st == 3), m_ft, m_lt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the flappy-bird datapath. Runs the IDLE/READY/PLAY/OVER state machine and generates the bird's `is_start` enable. Schedules fall/lift motion ticks from a single shared divider, scaled by difficulty level. Tracks score and level from pipe-pass events, and ends the game on a border drop-out or a pipe collision.

## Interface
Parameters:
- `FALL_DIV`, 700000: clock cycles per fall tick at level 0.
- `LIFT_DIV`, 900000: clock cycles per lift tick at level 0.
- `CNTDN_CYCLES`, 50000000: READY countdown length in cycles.
- `LEVEL_STEP`, 5: points per level increment.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `key_start` in 1: debounced start button, level.
- `key1` in 1: debounced flap button, level; high means lift.
- `bird_over` in 1: bird dropped out of the border, level.
- `hit` in 1: pipe collision, level.
- `pass_pulse` in 1: one-cycle pulse when the bird clears a pipe.
- `is_start` out 1: bird motion enable.
- `fall_tick` out 1: one-cycle pulse, move the bird down.
- `lift_tick` out 1: one-cycle pulse, move the bird up.
- `score` out 7: score in binary, 0..99.
- `level` out 2: difficulty level, 0..3.
- `state` out 2: IDLE=0, READY=1, PLAY=2, OVER=3 (PAUSE encoding is given under Configuration).
- `game_over` out 1: high in OVER.

## Operation
- Start edge: `start_rise = key_start & ~key_q`, where `key_q` is `key_start` registered. `key_q` resets to 1, so a button held through reset does not trigger a start.
- IDLE:
  - `score`, `level` and the divider are cleared.
  - `start_rise` goes to READY and loads the countdown with CNTDN_CYCLES-1.
- READY:
  - The countdown decrements each cycle; at 0 the FSM goes to PLAY.
  - `hit`, `bird_over` and `pass_pulse` are ignored.
- PLAY:
  - `is_start`=1.
  - The divider counts up. Its limit is `(key1 ? LIFT_DIV : FALL_DIV) >> level`, with a minimum limit of 1.
  - When `cnt == limit-1`, the block pulses `lift_tick` if `key1` is high, else `fall_tick`, and the divider clears.
  - If `key1` differs from its value on the previous cycle, the divider clears and no tick is issued that cycle.
  - `pass_pulse` increments `score`, saturating at 99.
  - Each time `score` reaches a nonzero multiple of LEVEL_STEP, `level` increments, saturating at 3.
  - `hit | bird_over` goes to OVER. If it coincides with `pass_pulse`, the collision wins and `score` is not incremented. No tick is issued in the transition cycle.
- OVER:
  - `game_over`=1, `is_start`=0; `score` and `level` are held.
  - `start_rise` goes to READY, clearing `score`, `level` and the divider.
- Ticks are never asserted outside PLAY, and `fall_tick` and `lift_tick` are never high together.
- Internal counter widths are sized by `$clog2` of the largest parameter.

## Timing
- All outputs are registered.
- Values after reset: state IDLE, `is_start`=0, both ticks 0, `score`=0, `level`=0, `game_over`=0.
- A `key_start` rise sampled at edge n gives `state`=READY after edge n+1.
- READY lasts exactly CNTDN_CYCLES cycles, then `is_start`=1.
- Tick spacing in steady PLAY is exactly `limit` cycles.
- `hit` sampled at edge n gives `state`=OVER and `is_start`=0 after edge n+1.
- `pass_pulse` at edge n gives the updated `score` after edge n+1. `level` updates in the same cycle.
- Asserting `rst` in any state returns all outputs to their reset values after that edge.

## Configuration
- `GAME_PAUSE_EN` defined:
  - `start_rise` in PLAY enters PAUSE (`state` encoding 3, with `game_over` distinguishing OVER).
  - In PAUSE: `is_start`=0, the divider holds its value, no ticks are issued, and `hit`, `bird_over` and `pass_pulse` are ignored.
  - The next `start_rise` resumes PLAY with the divider value intact.
- `GAME_PAUSE_EN` undefined:
  - `start_rise` in PLAY is ignored and there is no PAUSE state.

## Test plan
All scenarios use FALL_DIV=8, LIFT_DIV=12, CNTDN_CYCLES=4, LEVEL_STEP=2.
- Reset, pulse `key_start` -> READY for 4 cycles, then PLAY; with `key1`=0, `fall_tick` fires every 8 cycles.
- Hold `key1`=1 in PLAY -> the divider clears on the toggle, then `lift_tick` fires every 12 cycles with no `fall_tick`.
- Issue 2 `pass_pulse` -> `score`=2, `level`=1, `fall_tick` spacing becomes 4. Issue 8 more -> `level` saturates at 3, spacing 1. Force 99 points -> `score` stays 99.
- Assert `hit` and `pass_pulse` in the same cycle with `score`=3 -> OVER, `score`=3, `game_over`=1, no ticks. Then `key_start` -> READY with `score`=0.
- Hold `key_start` high across `rst` release -> stays in IDLE until a fresh rising edge. Assert `rst` mid-PLAY -> all outputs return to reset values the next cycle.
- With `GAME_PAUSE_EN`: `key_start` in PLAY holds the divider at its value (e.g. 5) with no ticks for 20 cycles. A second `key_start` resumes, and the next `fall_tick` comes 3 cycles later.
